// File: rtl/hazard_defs.sv
// Shared definitions for the hazard stall/flush controller: FSM encodings, the default
// memory-wait limit and the zero-register constant.
package hazard_defs;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StBrLd2   = 2'd1,
    StMemWait = 2'd2
  } state_e;

  localparam int unsigned WaitMaxDefault = 16;

  // r0 never creates a dependency.
  localparam logic [4:0] RegZero = 5'd0;

endpackage

// File: rtl/hazard_wait_timer.sv
// Saturating count of consecutive data-memory wait cycles, plus a sticky timeout flag
// that sets when the count reaches WAIT_MAX and holds until reset.
module hazard_wait_timer
  import hazard_defs::*;
#(
  parameter int unsigned WAIT_MAX = WaitMaxDefault
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_count_en,
  input  logic i_clear,
  output logic o_timeout
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_MAX);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_timeout;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clear) begin
      w_cnt_d = '0;
    end else if (i_count_en && (r_cnt != CntMax)) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_timeout <= r_timeout | (w_cnt_d == CntMax);
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller for hazards forwarding cannot resolve.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import hazard_defs::*;
#(
  parameter int unsigned WAIT_MAX = WaitMaxDefault
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_ifid_uses_rt,
  input  logic       i_ifid_branch,
  input  logic       i_branch_taken,
  input  logic       i_jump,
  input  logic [4:0] i_idex_rd,
  input  logic       i_idex_regwr,
  input  logic       i_idex_memrd,
  input  logic       i_exmem_memrd,
  input  logic       i_exmem_memwr,
  input  logic       i_dmem_ready,
  output logic       o_pc_wr,
  output logic       o_ifid_wr,
  output logic       o_idex_wr,
  output logic       o_exmem_wr,
  output logic       o_memwr_wr,
  output logic       o_ifid_flush,
  output logic       o_idex_flush,
  output logic       o_memwr_flush,
  output logic       o_mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  state_e r_state, w_state_d;
  logic   r_br_pend, w_br_pend_d;
  logic   w_lu, w_brd, w_mw, w_in_brld2, w_stall, w_redirect;

  assign w_lu = i_idex_memrd && (i_idex_rd != RegZero) &&
                ((i_idex_rd == i_ifid_rs) || (i_ifid_uses_rt && (i_idex_rd == i_ifid_rt)));
  assign w_brd = i_ifid_branch && i_idex_regwr && (i_idex_rd != RegZero) &&
                 ((i_idex_rd == i_ifid_rs) || (i_idex_rd == i_ifid_rt));
  assign w_mw = (i_exmem_memrd || i_exmem_memwr) && !i_dmem_ready;
  // A BR_LD2 interrupted by a memory freeze is resumed once the freeze ends.
  assign w_in_brld2 = (r_state == StBrLd2) || ((r_state == StMemWait) && r_br_pend);
  assign w_stall    = w_lu || w_brd || w_in_brld2;
  assign w_redirect = (i_branch_taken && i_ifid_branch) || i_jump;

  always_comb begin
    o_pc_wr       = 1'b1;
    o_ifid_wr     = 1'b1;
    o_idex_wr     = 1'b1;
    o_exmem_wr    = 1'b1;
    o_memwr_wr    = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_memwr_flush = 1'b0;
    w_state_d     = r_state;
    w_br_pend_d   = 1'b0;
    if (w_mw) begin
      o_pc_wr       = 1'b0;
      o_ifid_wr     = 1'b0;
      o_idex_wr     = 1'b0;
      o_exmem_wr    = 1'b0;
      o_memwr_flush = 1'b1;
      w_state_d     = StMemWait;
      w_br_pend_d   = w_in_brld2;
    end else if (w_stall) begin
      o_pc_wr      = 1'b0;
      o_ifid_wr    = 1'b0;
      o_idex_flush = 1'b1;
      w_state_d    = (w_brd && i_idex_memrd && !w_in_brld2) ? StBrLd2 : StRun;
    end else begin
      o_ifid_flush = w_redirect;
      w_state_d    = StRun;
    end
    if (i_rst) begin
      o_pc_wr       = 1'b0;
      o_ifid_wr     = 1'b0;
      o_idex_wr     = 1'b0;
      o_exmem_wr    = 1'b0;
      o_memwr_wr    = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_memwr_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StRun;
      r_br_pend <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_br_pend <= w_br_pend_d;
    end
  end

  hazard_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_count_en(w_mw),
    .i_clear   (!w_mw),
    .o_timeout (o_mem_timeout)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!o_pc_wr && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (o_ifid_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected control vectors are queued as each
// cycle's stimulus is driven and compared when the outputs are sampled on the falling edge.
module tb_hazard_stall_ctrl;

  // {pc, ifid, idex, exmem, memwr, ifid_fl, idex_fl, memwr_fl, timeout}
  localparam logic [8:0] ExpRun   = 9'b11111_000_0;
  localparam logic [8:0] ExpStall = 9'b00111_010_0;
  localparam logic [8:0] ExpRedir = 9'b11111_100_0;
  localparam logic [8:0] ExpFrz   = 9'b00001_001_0;
  localparam logic [8:0] ExpRst   = 9'b00000_111_0;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rd;
  logic       ifid_uses_rt, ifid_branch, branch_taken, jump;
  logic       idex_regwr, idex_memrd, exmem_memrd, exmem_memwr, dmem_ready;
  logic       pc_wr, ifid_wr, idex_wr, exmem_wr, memwr_wr;
  logic       ifid_flush, idex_flush, memwr_flush, mem_timeout;
  logic [8:0] obs;
  logic [8:0] exp_q[$];
  logic       to_m;
  int         n_checks = 0;
  int         n_errors = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  int          stall_m = 0;
  int          flush_m = 0;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ifid_rs     (ifid_rs),
    .i_ifid_rt     (ifid_rt),
    .i_ifid_uses_rt(ifid_uses_rt),
    .i_ifid_branch (ifid_branch),
    .i_branch_taken(branch_taken),
    .i_jump        (jump),
    .i_idex_rd     (idex_rd),
    .i_idex_regwr  (idex_regwr),
    .i_idex_memrd  (idex_memrd),
    .i_exmem_memrd (exmem_memrd),
    .i_exmem_memwr (exmem_memwr),
    .i_dmem_ready  (dmem_ready),
    .o_pc_wr       (pc_wr),
    .o_ifid_wr     (ifid_wr),
    .o_idex_wr     (idex_wr),
    .o_exmem_wr    (exmem_wr),
    .o_memwr_wr    (memwr_wr),
    .o_ifid_flush  (ifid_flush),
    .o_idex_flush  (idex_flush),
    .o_memwr_flush (memwr_flush),
    .o_mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cnt (stall_cnt),
    .o_flush_cnt   (flush_cnt)
`endif
  );

  assign obs = {pc_wr, ifid_wr, idex_wr, exmem_wr, memwr_wr,
                ifid_flush, idex_flush, memwr_flush, mem_timeout};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic idle_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rd = 5'd0;
    ifid_uses_rt = 1'b0; ifid_branch = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    idex_regwr = 1'b0; idex_memrd = 1'b0;
    exmem_memrd = 1'b0; exmem_memwr = 1'b0; dmem_ready = 1'b1;
  endtask

  // One pipeline cycle: queue the expectation, compare mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic [8:0] base);
    exp_q.push_back(base | {8'd0, to_m});
    @(negedge clk);
    check_eq(tag, 32'(obs), 32'(exp_q.pop_front()));
`ifdef HAZARD_PERF_CNT_EN
    check_eq({tag, "_stall_cnt"}, stall_cnt, 32'(stall_m));
    check_eq({tag, "_flush_cnt"}, flush_cnt, 32'(flush_m));
`endif
    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    if (rst) begin
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (!base[8]) stall_m++;
      if (base[3]) flush_m++;
    end
`endif
    #1;
  endtask

  task automatic lw_beq_r5();
    idle_inputs();
    ifid_branch = 1'b1; ifid_rs = 5'd5; branch_taken = 1'b1;
    idex_memrd = 1'b1; idex_regwr = 1'b1; idex_rd = 5'd5;
  endtask

  initial begin
    to_m = 1'b0;
    rst  = 1'b1;
    idle_inputs();
    step("reset", ExpRst);
    rst = 1'b0;
    step("idle", ExpRun);

    // Load-use on Rs, then the bubble moves on.
    idex_memrd = 1'b1; idex_regwr = 1'b1; idex_rd = 5'd2; ifid_rs = 5'd2;
    step("lu_rs", ExpStall);
    idle_inputs(); exmem_memrd = 1'b1;
    step("lu_after", ExpRun);
    // Rt only matters when the ID instruction reads it.
    idle_inputs(); idex_memrd = 1'b1; idex_regwr = 1'b1; idex_rd = 5'd3; ifid_rt = 5'd3;
    ifid_rs = 5'd9;
    step("lu_rt_unused", ExpRun);
    ifid_uses_rt = 1'b1;
    step("lu_rt_used", ExpStall);

    // Load feeding beq: two bubbles, stale taken must not redirect.
    lw_beq_r5();
    step("lwbeq_1", ExpStall);
    idex_memrd = 1'b0; idex_regwr = 1'b0; idex_rd = 5'd0; exmem_memrd = 1'b1;
    step("lwbeq_2", ExpStall);
    exmem_memrd = 1'b0;
    step("lwbeq_redir", ExpRedir);
    idle_inputs();
    step("lwbeq_done", ExpRun);

    // ALU result feeding beq via Rt: one bubble.
    ifid_branch = 1'b1; ifid_rt = 5'd7; idex_regwr = 1'b1; idex_rd = 5'd7;
    step("alubeq_1", ExpStall);
    idex_regwr = 1'b0; idex_rd = 5'd0;
    step("alubeq_2", ExpRun);

    // Redirects and r0.
    idle_inputs(); ifid_branch = 1'b1; branch_taken = 1'b1;
    step("beq_taken", ExpRedir);
    idle_inputs(); ifid_branch = 1'b1;
    step("beq_not_taken", ExpRun);
    idle_inputs(); jump = 1'b1;
    step("jump", ExpRedir);
    idle_inputs(); idex_memrd = 1'b1; idex_regwr = 1'b1; idex_rd = 5'd0;
    ifid_branch = 1'b1; ifid_uses_rt = 1'b1;
    step("r0_ignored", ExpRun);

    // Store waits three cycles.
    idle_inputs(); exmem_memwr = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("sw_wait", ExpFrz);
    dmem_ready = 1'b1;
    step("sw_done", ExpRun);

    // Freeze beats load-use; load-use is seen again afterwards.
    idle_inputs(); exmem_memrd = 1'b1; dmem_ready = 1'b0;
    idex_memrd = 1'b1; idex_regwr = 1'b1; idex_rd = 5'd4; ifid_rs = 5'd4;
    step("mw_lu_1", ExpFrz);
    step("mw_lu_2", ExpFrz);
    dmem_ready = 1'b1;
    step("mw_lu_stall", ExpStall);
    idle_inputs();
    step("mw_lu_done", ExpRun);

    // BR_LD2 interrupted by a freeze resumes afterwards.
    lw_beq_r5();
    step("pend_1", ExpStall);
    idex_memrd = 1'b0; idex_regwr = 1'b0; idex_rd = 5'd0; branch_taken = 1'b0;
    exmem_memrd = 1'b1; dmem_ready = 1'b0;
    step("pend_frz", ExpFrz);
    dmem_ready = 1'b1;
    step("pend_resume", ExpStall);
    exmem_memrd = 1'b0;
    step("pend_done", ExpRun);

    // Sixteen wait cycles reach the timeout, which then sticks.
    idle_inputs(); exmem_memrd = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step("wait16", ExpFrz);
    to_m = 1'b1;
    dmem_ready = 1'b1;
    step("timeout_set", ExpRun);
    idle_inputs();
    step("timeout_sticky", ExpRun);

    // Reset mid-wait clears everything at once.
    exmem_memwr = 1'b1; dmem_ready = 1'b0;
    step("wait_pre_rst", ExpFrz);
    rst = 1'b1; to_m = 1'b0;
    step("rst_mid_wait", ExpRst);
    rst = 1'b0; idle_inputs();
    step("after_rst_wait", ExpRun);

    // Reset mid-BR_LD2 drops the pending bubble.
    lw_beq_r5();
    step("brld2_pre_rst", ExpStall);
    rst = 1'b1;
    idex_memrd = 1'b0; idex_regwr = 1'b0; idex_rd = 5'd0; branch_taken = 1'b0;
    step("rst_mid_brld2", ExpRst);
    rst = 1'b0;
    step("after_rst_brld2", ExpRun);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall/flush controller that sits directly downstream of the forwarding unit. It covers the hazards forwarding cannot resolve: load-use, branch operands still in flight, taken-branch wrong-path fetch, and data-memory wait states. It drives the write enables and flush strobes of PC, IF/ID, ID/EX, EX/MEM and MEM/WR. A small FSM handles the multi-cycle cases (load feeding an ID-stage branch; memory wait with timeout).

## Interface
- WAIT_MAX, 16: maximum consecutive dmem wait cycles before `mem_timeout` asserts.
- CNT_W, 32: width of the performance counters.

- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- IFID_Rs, IFID_Rt  in  5 each  source registers of the instruction in ID.
- IFID_UsesRt  in  1  ID instruction reads Rt (R-type, beq/bne, sw).
- IFID_Branch  in  1  ID instruction is beq/bne (compared in ID).
- branch_taken  in  1  ID compare result, valid when IFID_Branch.
- jump  in  1  ID instruction is j/jal/jr.
- IDEX_Rd  in  5  destination register of the instruction in EX.
- IDEX_RegWr, IDEX_MemRd  in  1 each  EX instruction writes a register / is a load.
- EXMEM_MemRd, EXMEM_MemWr  in  1 each  MEM-stage access.
- dmem_ready  in  1  data memory completes the access this cycle.
- PC_Wr, IFID_Wr, IDEX_Wr, EXMEM_Wr, MEMWR_Wr  out  1 each  stage register enables.
- IFID_Flush, IDEX_Flush, MEMWR_Flush  out  1 each  insert a bubble (zero control) into that register.
- mem_timeout  out  1  sticky error flag.
- stall_cnt, flush_cnt  out  CNT_W each  present only with the macro.

## Operation
- FSM states: RUN, BR_LD2, MEM_WAIT. Reset state is RUN.
- Hazard terms:
  - LU = IDEX_MemRd && IDEX_Rd!=0 && (IDEX_Rd==IFID_Rs || (IFID_UsesRt && IDEX_Rd==IFID_Rt)).
  - BRD = IFID_Branch && IDEX_RegWr && IDEX_Rd!=0 && (IDEX_Rd matches IFID_Rs or IFID_Rt).
  - MW = (EXMEM_MemRd || EXMEM_MemWr) && !dmem_ready.
- Priority, highest first: MW, then stall (LU or BRD or state BR_LD2), then redirect (branch_taken&&IFID_Branch, or jump).
- **MW (freeze):** all *_Wr=0 except MEMWR_Wr=1; MEMWR_Flush=1. The FSM enters or stays in MEM_WAIT. The wait counter increments, saturating at WAIT_MAX; at WAIT_MAX, mem_timeout sets and stays set until reset.
- **Stall:** PC_Wr=IFID_Wr=0 and IDEX_Flush=1; downstream enables stay 1. When BRD and IDEX_MemRd are both true, the next state is BR_LD2, which forces exactly one further stall cycle and then returns to RUN.
- **Redirect (no stall):** IFID_Flush=1 and all enables 1. This applies only when the branch operands are resolved; redirect is suppressed while any stall term is active.
- **RUN, no hazard:** all enables 1, all flushes 0.
- **MEM_WAIT exit:** when dmem_ready rises, return to RUN and clear the wait counter. If BR_LD2 was pending when the freeze began, it is held and resumed afterwards.

## Timing
- Outputs are combinational (Mealy) from the registered state and the current inputs. There is no output latency.
- While rst is high: all *_Wr=0, all *_Flush=1, mem_timeout=0, counters 0, state RUN.
- State, wait counter and perf counters update on the rising clk edge.
- Load-use costs 1 bubble. Load feeding an ID-stage branch costs 2 bubbles. ALU result feeding an ID-stage branch costs 1 bubble. A taken branch or jump costs 1 flushed slot.
- Reset asserted mid-MEM_WAIT or mid-BR_LD2 aborts immediately to RUN.
- MW and LU in the same cycle: the freeze wins and LU is re-evaluated after the wait.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with PC_Wr=0.
  - flush_cnt increments on every cycle with IFID_Flush=1.
  - Both saturate at all-ones.
- HAZARD_PERF_CNT_EN undefined: the counter ports and logic are absent.

## Structure
- Shared package/header hazard_defs holds:
  - the state encodings (RUN=2'd0, BR_LD2=2'd1, MEM_WAIT=2'd2);
  - the default WAIT_MAX;
  - the bubble/zero-register constant.
- One sub-module: hazard_wait_timer, a saturating wait counter plus the sticky timeout flag, with inputs clk, rst, count_en, clear.

## Test plan
- lw $2 in EX (IDEX_MemRd=1, IDEX_Rd=2), add using IFID_Rs=2 in ID -> one cycle with PC_Wr=0, IFID_Wr=0, IDEX_Flush=1; next cycle all enables 1.
- lw $5 in EX, beq reading $5 in ID -> PC_Wr=0 for exactly 2 cycles, and state passes through BR_LD2. The same case with an ALU op instead of lw -> exactly 1 stall cycle.
- beq taken with no dependency -> IFID_Flush=1 for 1 cycle, PC_Wr=1. With IDEX_Rd=0 and IDEX_MemRd=1 -> no stall (r0 is ignored).
- sw in MEM with dmem_ready low for 3 cycles -> PC_Wr/IFID_Wr/IDEX_Wr/EXMEM_Wr=0 and MEMWR_Flush=1 for 3 cycles, then RUN; mem_timeout stays 0.
- dmem_ready held low for 16 cycles (WAIT_MAX=16) -> mem_timeout=1 and stays set after ready. rst pulse mid-wait -> all outputs take their reset values at once, and mem_timeout clears.
- With HAZARD_PERF_CNT_EN: the scenarios above in sequence -> stall_cnt=1+2+3, flush_cnt=1, neither wrapping.
